// File: rtl/ntt_poly_loader.sv
// Serial-to-parallel coefficient loader ahead of the NTT pointwise multiplier; poly_valid rises the cycle
// after beat N is accepted. in_ready is high only while filling, so upstream stalls during FULL until poly_ack.
module ntt_poly_loader #(
  parameter int N     = 256,
  parameter int WIDTH = 32,
  parameter int Q     = 3329
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         poly_a [N-1:0],
  output logic [WIDTH-1:0]         poly_b [N-1:0],
  output logic                     poly_valid,
  input  logic                     poly_ack,
  output logic [$clog2(N+1)-1:0]   fill_count,
  output logic                     range_err
);

  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
  localparam logic [WIDTH-1:0] QLIM = WIDTH'(Q);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]    state;
  logic          accept;
  logic          beat_err;
  logic          last_beat;
  logic [IW-1:0] wr_idx;

  assign in_ready   = (state == FILL);
  assign poly_valid = (state == FULL);

  // A start in FILL wins over a same-cycle beat: the beat belongs to the abandoned load.
  assign accept    = in_ready && in_valid && !start;
  assign beat_err  = (in_a >= QLIM) || (in_b >= QLIM);
  assign last_beat = (fill_count == CW'(N-1));
  assign wr_idx    = fill_count[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fill_count <= '0;
      range_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            fill_count <= '0;
            range_err  <= 1'b0;
          end
        end
        FILL: begin
          if (start) begin
            fill_count <= '0;
            range_err  <= 1'b0;
          end else if (in_valid) begin
            fill_count <= fill_count + CW'(1);
            if (beat_err) range_err <= 1'b1;
            if (last_beat) state <= FULL;
          end
        end
        FULL: begin
          if (poly_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Banks are written only on accepted beats, so they stay frozen through FULL and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        poly_a[i] <= '0;
        poly_b[i] <= '0;
      end
    end else if (accept) begin
      poly_a[wr_idx] <= in_a;
      poly_b[wr_idx] <= in_b;
    end
  end

endmodule
